// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: opcode / funct3 / funct7 constants,
// machine CSR addresses, the ALU operation enum and the ALU itself.
// No ports (package). Optional CSR/trap support is selected in core.sv by
// the CORE_CSR_EN macro; nothing here depends on it.
package core_pkg;

  // Major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct7 selecting SUB / SRA / SRAI (only bit 30 is inspected)
  localparam logic [6:0] F7_ALT = 7'b0100000;

  // SYSTEM funct12 values for the non-CSR instructions
  localparam logic [11:0] F12_ECALL = 12'h000;
  localparam logic [11:0] F12_MRET  = 12'h302;

  // Machine CSR addresses
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;

  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (op)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: r = {31'd0, a < b};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $signed(a) >>> b[4:0];
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      default:  r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_memory.sv
// Unified instruction/data memory for the core (module name: memory).
// Ports:
//   clk    - write clock (rising edge)
//   iidx   - fetch word index,  idata  - fetched word (combinational)
//   didx   - data word index,   drdata - data read word (combinational)
//   dwdata - write data (lanes already replicated), dbe - byte enables
// Little-endian: byte lane 0 is bits [7:0]. Contents are never reset so a
// preloaded image survives core reset.
module memory #(
  parameter int MEM_WORDS = 65536
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_WORDS)-1:0] iidx,
  output logic [31:0]                  idata,
  input  logic [$clog2(MEM_WORDS)-1:0] didx,
  output logic [31:0]                  drdata,
  input  logic [31:0]                  dwdata,
  input  logic [3:0]                   dbe
);

  logic [31:0] m [0:MEM_WORDS-1];

  assign idata  = m[iidx];
  assign drdata = m[didx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dbe[i]) m[didx][8*i +: 8] <= dwdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/core.sv
// Single-cycle RV32I core with a unified word memory.
// Ports:
//   clk - clock, all state updates on the rising edge
//   rst - asynchronous active-low reset
// Visible state for loaders/checkers: memory.m[], rs[0:31], csr[0:4095], pc.
// Build option CORE_CSR_EN: enables Zicsr instructions, ECALL/MRET and the
// illegal-opcode trap. Without it CSR instructions return 0 in rd and
// ECALL/MRET/unknown opcodes fall through to pc+4.
module core
  import core_pkg::*;
#(
  parameter int          MEM_WORDS = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] pc;
  logic [31:0] rs  [0:31];
  logic [31:0] csr [0:4095];

  logic [31:0] instr, drdata, dwdata, daddr;
  logic [3:0]  dbe, dbe_req;

  memory #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk    (clk),
    .iidx   (pc[AW+1:2]),
    .idata  (instr),
    .didx   (daddr[AW+1:2]),
    .drdata (drdata),
    .dwdata (dwdata),
    .dbe    (dbe)
  );

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1a, rs2a;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rv1, rv2;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1a   = instr[19:15];
  assign rs2a   = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'd0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to zero on read regardless of array contents
  assign rv1 = (rs1a == 5'd0) ? 32'd0 : rs[rs1a];
  assign rv2 = (rs2a == 5'd0) ? 32'd0 : rs[rs2a];

  // ALU operand / operation select; bit 30 means SUB only for register ops
  alu_op_t     alu_op;
  logic [31:0] alu_b, alu_res;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = (opcode == OP_OP) ? rv2 : imm_i;
    case (f3)
      F3_ADD:  alu_op = (opcode == OP_OP && instr[30] == F7_ALT[5]) ? ALU_SUB : ALU_ADD;
      F3_SLL:  alu_op = ALU_SLL;
      F3_SLT:  alu_op = ALU_SLT;
      F3_SLTU: alu_op = ALU_SLTU;
      F3_XOR:  alu_op = ALU_XOR;
      F3_SR:   alu_op = instr[30] ? ALU_SRA : ALU_SRL;
      F3_OR:   alu_op = ALU_OR;
      F3_AND:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign alu_res = alu(alu_op, rv1, alu_b);

  // Branch condition
  logic taken;
  always_comb begin
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = (rv1 == rv2);
      F3_BNE:  taken = (rv1 != rv2);
      F3_BLT:  taken = ($signed(rv1) <  $signed(rv2));
      F3_BGE:  taken = ($signed(rv1) >= $signed(rv2));
      F3_BLTU: taken = (rv1 <  rv2);
      F3_BGEU: taken = (rv1 >= rv2);
      default: taken = 1'b0;
    endcase
  end

  // Data path: loads pick lanes from the aligned word, stores replicate
  // the source so the byte enables alone select the destination lanes.
  logic [31:0] ld_byte, ld_half, load_val;
  assign daddr   = rv1 + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ld_byte = drdata >> {daddr[1:0], 3'b000};
  assign ld_half = daddr[1] ? {16'd0, drdata[31:16]} : {16'd0, drdata[15:0]};

  always_comb begin
    load_val = drdata;
    case (f3)
      F3_B:    load_val = {{24{ld_byte[7]}}, ld_byte[7:0]};
      F3_H:    load_val = {{16{ld_half[15]}}, ld_half[15:0]};
      F3_W:    load_val = drdata;
      F3_BU:   load_val = {24'd0, ld_byte[7:0]};
      F3_HU:   load_val = {16'd0, ld_half[15:0]};
      default: load_val = drdata;
    endcase
  end

  always_comb begin
    dwdata  = rv2;
    dbe_req = 4'b1111;
    case (f3)
      F3_B: begin
        dwdata  = {4{rv2[7:0]}};
        dbe_req = 4'b0001 << daddr[1:0];
      end
      F3_H: begin
        dwdata  = {2{rv2[15:0]}};
        dbe_req = daddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dwdata  = rv2;
        dbe_req = 4'b1111;
      end
    endcase
  end

  // CSR read side; mhartid is hard-wired to zero
  logic [11:0] csr_addr;
  logic [31:0] csr_old;
  assign csr_addr = instr[31:20];
  assign csr_old  = (csr_addr == CSR_MHARTID) ? 32'd0 : csr[csr_addr];

`ifdef CORE_CSR_EN
  logic [31:0] csr_src, csr_new, trap_cause;
  logic        csr_we, trap;
  assign csr_src = f3[2] ? {27'd0, rs1a} : rv1;
  always_comb begin
    csr_new = csr_old;
    case (f3[1:0])
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      2'b11:   csr_new = csr_old & ~csr_src;
      default: csr_new = csr_old;
    endcase
  end
`endif

  // Next-pc / writeback control
  logic [31:0] next_pc, rd_val;
  logic        rd_we, store_en;

  always_comb begin
    next_pc  = pc + 32'd4;
    rd_we    = 1'b0;
    rd_val   = alu_res;
    store_en = 1'b0;
`ifdef CORE_CSR_EN
    csr_we     = 1'b0;
    trap       = 1'b0;
    trap_cause = 32'd0;
`endif
    case (opcode)
      OP_LUI:    begin rd_we = 1'b1; rd_val = imm_u; end
      OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc + imm_u; end
      OP_JAL:    begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
      OP_JALR:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = (rv1 + imm_i) & ~32'd1; end
      OP_BRANCH: if (taken) next_pc = pc + imm_b;
      OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
      OP_STORE:  store_en = 1'b1;
      OP_IMM,
      OP_OP:     rd_we = 1'b1;
      OP_FENCE:  ;
      OP_SYSTEM: begin
        if (f3[1:0] != 2'b00) begin
          // Without CSR support the file is never written, so this reads 0
          rd_we  = 1'b1;
          rd_val = csr_old;
`ifdef CORE_CSR_EN
          csr_we = (f3[1:0] == 2'b01) || (rs1a != 5'd0);
`endif
        end
`ifdef CORE_CSR_EN
        else if (f3 == 3'b000 && csr_addr == F12_ECALL) begin
          trap       = 1'b1;
          trap_cause = CAUSE_ECALL_M;
        end else if (f3 == 3'b000 && csr_addr == F12_MRET) begin
          next_pc = csr[CSR_MEPC];
        end
`endif
      end
      default: begin
`ifdef CORE_CSR_EN
        trap       = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
`endif
      end
    endcase
`ifdef CORE_CSR_EN
    if (trap) next_pc = csr[CSR_MTVEC];
`endif
  end

  // Memory writes are suppressed while reset is held
  assign dbe = (store_en && rst) ? dbe_req : 4'b0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) rs[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (rd_we && rd != 5'd0) rs[rd] <= rd_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) csr[i] <= 32'd0;
    end else begin
`ifdef CORE_CSR_EN
      if (trap) begin
        csr[CSR_MEPC]   <= pc;
        csr[CSR_MCAUSE] <= trap_cause;
      end else if (csr_we && csr_addr != CSR_MHARTID) begin
        csr[csr_addr] <= csr_new;
      end
`endif
    end
  end

endmodule

// File: tb/tb_core.sv
// Testbench for core: directed programs for reset, loads/stores, branches,
// jumps and CSR/trap behaviour, then a random program checked cycle by
// cycle against an instruction-level model of the ISA.
module tb_core;

  logic clk;
  logic rst;

  int tests = 0;
  int fails = 0;

  core dut (.clk(clk), .rst(rst));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v, r1, f, d;
    v = imm; r1 = rs1; f = f3; d = rd;
    return {v[11:0], r1[4:0], f[2:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    logic [31:0] s, r2, r1, f, d;
    s = f7; r2 = rs2; r1 = rs1; f = f3; d = rd;
    return {s[6:0], r2[4:0], r1[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, r2, r1, f;
    v = imm; r2 = rs2; r1 = rs1; f = f3;
    return {v[11:5], r2[4:0], r1[4:0], f[2:0], v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v, r2, r1, f;
    v = imm; r2 = rs2; r1 = rs1; f = f3;
    return {v[12], v[10:5], r2[4:0], r1[4:0], f[2:0], v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input int rd, input logic [6:0] op);
    logic [31:0] d;
    d = rd;
    return {imm20[19:0], d[4:0], op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v, d;
    v = imm; d = rd;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic put(input int idx, input logic [31:0] w);
    dut.memory.m[idx] = w;
  endtask

  // Enter reset and clear the program area
  task automatic start();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 64; k++) put(k, 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Let n rising edges pass, then park on the falling edge
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mr [0:31];
  logic [31:0] mm [0:2047];
  logic [31:0] mpc;

  task automatic setr(input logic [4:0] rd, input logic [31:0] v);
    if (rd != 5'd0) mr[rd] = v;
  endtask

  task automatic iss_step();
    logic [31:0] ins, a, b, iimm, simm, bimm, jimm, uimm, npc, addr, w, wb, wh, v;
    logic [6:0] op;
    logic [4:0] rd;
    logic [2:0] f3;
    logic tk;
    int lo, n, idx;
    ins  = mm[mpc[12:2]];
    op   = ins[6:0];
    rd   = ins[11:7];
    f3   = ins[14:12];
    a    = mr[ins[19:15]];
    b    = mr[ins[24:20]];
    iimm = {{20{ins[31]}}, ins[31:20]};
    simm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bimm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    jimm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    uimm = {ins[31:12], 12'd0};
    npc  = mpc + 4;
    case (op)
      7'h37: setr(rd, uimm);
      7'h17: setr(rd, mpc + uimm);
      7'h6f: begin setr(rd, mpc + 4); npc = mpc + jimm; end
      7'h67: begin npc = (a + iimm) & 32'hFFFF_FFFE; setr(rd, mpc + 4); end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = $signed(a) < $signed(b);
          3'd5: tk = $signed(a) >= $signed(b);
          3'd6: tk = a < b;
          default: tk = a >= b;
        endcase
        if (tk) npc = mpc + bimm;
      end
      7'h03: begin
        addr = a + iimm;
        w  = mm[addr[12:2]];
        wb = w >> (8 * addr[1:0]);
        wh = w >> (16 * addr[1]);
        case (f3)
          3'd0: v = {{24{wb[7]}}, wb[7:0]};
          3'd1: v = {{16{wh[15]}}, wh[15:0]};
          3'd4: v = {24'd0, wb[7:0]};
          3'd5: v = {16'd0, wh[15:0]};
          default: v = w;
        endcase
        setr(rd, v);
      end
      7'h23: begin
        addr = a + simm;
        idx  = addr[12:2];
        if (f3 == 3'd0) begin lo = addr[1:0]; n = 1; end
        else if (f3 == 3'd1) begin lo = 2 * addr[1]; n = 2; end
        else begin lo = 0; n = 4; end
        for (int k = 0; k < n; k++) mm[idx][8*(lo+k) +: 8] = b[8*k +: 8];
      end
      7'h13, 7'h33: begin
        if (op == 7'h13) b = iimm;
        case (f3)
          3'd0: v = (op == 7'h33 && ins[30]) ? a - b : a + b;
          3'd1: v = a << b[4:0];
          3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: v = (a < b) ? 32'd1 : 32'd0;
          3'd4: v = a ^ b;
          3'd5: v = ins[30] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
          3'd6: v = a | b;
          default: v = a & b;
        endcase
        setr(rd, v);
      end
      default: ;
    endcase
    mpc = npc;
  endtask

  // Random instruction; loads/stores go through x31 into 0x1000..0x1FFF,
  // control transfers only skip forward one instruction.
  function automatic logic [31:0] gen_rand();
    int kind, rd, rs1, rs2, f3, imm, off, pick;
    kind = $urandom_range(0, 9);
    rd   = $urandom_range(1, 30);
    rs1  = $urandom_range(0, 31);
    rs2  = $urandom_range(0, 31);
    f3   = $urandom_range(0, 7);
    case (kind)
      0, 1, 2: begin
        if (f3 == 1) imm = $urandom_range(0, 31);
        else if (f3 == 5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) * 1024);
        else imm = $urandom_range(0, 4095);
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      3, 4: return enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0, rs2, rs1, f3, rd);
      5: return enc_u($urandom, rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      6: begin
        pick = $urandom_range(0, 4);
        f3   = (pick < 3) ? pick : pick + 1;
        off  = $urandom_range(0, 4095) - 2048;
        if (f3 == 1 || f3 == 5) off = off & ~1;
        if (f3 == 2) off = off & ~3;
        return enc_i(off, 31, f3, rd, 7'h03);
      end
      7: begin
        f3  = $urandom_range(0, 2);
        off = $urandom_range(0, 4095) - 2048;
        if (f3 == 1) off = off & ~1;
        if (f3 == 2) off = off & ~3;
        return enc_s(off, rs2, 31, f3);
      end
      8: begin
        pick = $urandom_range(0, 5);
        return enc_b(8, rs2, rs1, (pick < 2) ? pick : pick + 2);
      end
      default: return enc_j(8, $urandom_range(0, 30));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  localparam int NPROG = 160;

  initial begin
    rst = 1'b0;

    // Reset state and first instruction
    put(0, enc_i(1, 0, 0, 3, 7'h13));      // addi x3,x0,1
    put(1, enc_j(0, 0));                   // jal x0,0
    run(2);
    check("reset_pc", dut.pc, 32'h0);
    check("reset_x3", dut.rs[3], 32'h0);
    check("reset_csr", dut.csr[12'h305], 32'h0);
    release_rst();
    run(1);
    check("addi_x3", dut.rs[3], 32'h1);
    check("addi_pc", dut.pc, 32'h4);

    // Reset clears registers but keeps memory
    @(negedge clk);
    rst = 1'b0;
    run(1);
    check("rerst_x3", dut.rs[3], 32'h0);
    check("rerst_mem", dut.memory.m[0], enc_i(1, 0, 0, 3, 7'h13));

    // Word store then byte/halfword loads
    start();
    put(0, enc_u(32'h2, 1, 7'h37));          // lui x1,0x2
    put(1, enc_u(32'h00FF0, 2, 7'h37));      // lui x2,0x00FF0
    put(2, enc_i(255, 2, 0, 2, 7'h13));      // addi x2,x2,0xFF
    put(3, enc_s(0, 2, 1, 2));               // sw x2,0(x1)
    put(4, enc_i(1, 1, 4, 3, 7'h03));        // lbu x3,1(x1)
    put(5, enc_i(0, 1, 0, 4, 7'h03));        // lb x4,0(x1)
    put(6, enc_i(2, 1, 1, 5, 7'h03));        // lh x5,2(x1)
    release_rst();
    run(7);
    check("sw_word", dut.memory.m[12'h800], 32'h00FF00FF);
    check("lbu_off1", dut.rs[3], 32'h0);
    check("lb_off0", dut.rs[4], 32'hFFFFFFFF);
    check("lh_off2", dut.rs[5], 32'h000000FF);

    // Byte store into the top lane
    start();
    put(12'h800, 32'h11223344);
    put(0, enc_u(32'h2, 1, 7'h37));          // lui x1,0x2
    put(1, enc_i(171, 0, 0, 2, 7'h13));      // addi x2,x0,0xAB
    put(2, enc_s(3, 2, 1, 0));               // sb x2,3(x1)
    release_rst();
    run(3);
    check("sb_lane3", dut.memory.m[12'h800], 32'hAB223344);

    // Signed vs unsigned branch, arithmetic shift
    start();
    put(0, enc_i(-1, 0, 0, 1, 7'h13));       // addi x1,x0,-1
    put(1, enc_i(1, 0, 0, 2, 7'h13));        // addi x2,x0,1
    put(2, enc_b(8, 2, 1, 4));               // blt x1,x2,+8
    put(3, enc_i(5, 0, 0, 5, 7'h13));        // addi x5,x0,5 (skipped)
    put(4, enc_b(8, 2, 1, 6));               // bltu x1,x2,+8 (not taken)
    put(5, enc_i(6, 0, 0, 6, 7'h13));        // addi x6,x0,6
    put(6, enc_i(32'h404, 1, 5, 7, 7'h13));  // srai x7,x1,4
    put(7, enc_j(0, 0));
    release_rst();
    run(3);
    check("blt_taken_pc", dut.pc, 32'h10);
    run(1);
    check("bltu_nt_pc", dut.pc, 32'h14);
    run(2);
    check("skipped_x5", dut.rs[5], 32'h0);
    check("exec_x6", dut.rs[6], 32'h6);
    check("srai_x7", dut.rs[7], 32'hFFFFFFFF);
    check("branch_end_pc", dut.pc, 32'h1C);

    // JALR with rd == rs1, bit-0 clear, x0 discard
    start();
    put(0, enc_i(33, 0, 0, 1, 7'h13));       // addi x1,x0,0x21
    put(1, enc_i(0, 1, 0, 1, 7'h67));        // jalr x1,0(x1)
    put(8, enc_i(5, 0, 0, 0, 7'h13));        // addi x0,x0,5
    put(9, enc_r(0, 1, 0, 0, 8));            // add x8,x0,x1
    release_rst();
    run(2);
    check("jalr_pc", dut.pc, 32'h20);
    check("jalr_link", dut.rs[1], 32'h8);
    run(2);
    check("x0_zero", dut.rs[0], 32'h0);
    check("add_x8", dut.rs[8], 32'h8);

    // CSR and trap behaviour
    start();
`ifdef CORE_CSR_EN
    put(0, enc_i(64, 0, 0, 1, 7'h13));       // addi x1,x0,0x40
    put(1, enc_i(32'h305, 1, 1, 2, 7'h73));  // csrrw x2,mtvec,x1
    put(2, enc_i(32'h305, 0, 2, 3, 7'h73));  // csrrs x3,mtvec,x0
    put(3, enc_j(20, 0));                    // jal x0,0x20
    put(8, 32'h00000073);                    // ecall
    put(16, 32'h30200073);                   // mret
    release_rst();
    run(4);
    check("csrrw_old", dut.rs[2], 32'h0);
    check("csrrs_read", dut.rs[3], 32'h40);
    check("jal_pc", dut.pc, 32'h20);
    run(1);
    check("ecall_pc", dut.pc, 32'h40);
    check("mepc", dut.csr[12'h341], 32'h20);
    check("mcause", dut.csr[12'h342], 32'd11);
    run(1);
    check("mret_pc", dut.pc, 32'h20);
`else
    put(0, enc_i(64, 0, 0, 1, 7'h13));       // addi x1,x0,0x40
    put(1, enc_i(7, 0, 0, 2, 7'h13));        // addi x2,x0,7
    put(2, enc_i(32'h305, 1, 1, 2, 7'h73));  // csrrw x2,mtvec,x1
    put(3, 32'h00000073);                    // ecall
    put(4, 32'h30200073);                    // mret
    put(5, 32'h0000000B);                    // unknown opcode
    release_rst();
    run(6);
    check("csr_rd_zero", dut.rs[2], 32'h0);
    check("csr_nowrite", dut.csr[12'h305], 32'h0);
    check("nop_sys_pc", dut.pc, 32'h18);
`endif

    // Reset falling while a store is pending commits nothing
    start();
    put(12'h800, 32'h0);
    put(0, enc_u(32'h2, 1, 7'h37));          // lui x1,0x2
    put(1, enc_i(85, 0, 0, 2, 7'h13));       // addi x2,x0,0x55
    put(2, enc_s(0, 2, 1, 2));               // sw x2,0(x1)
    release_rst();
    run(2);
    check("inflight_pc", dut.pc, 32'h8);
    #1 rst = 1'b0;
    run(1);
    check("inflight_mem", dut.memory.m[12'h800], 32'h0);
    check("inflight_pc_rst", dut.pc, 32'h0);
    check("inflight_x2", dut.rs[2], 32'h0);

    // Random program against the model
    start();
    for (int k = 0; k < 2048; k++) mm[k] = 32'd0;
    for (int k = 12'h400; k < 12'h800; k++) mm[k] = $urandom;
    mm[0] = enc_u(32'h2, 31, 7'h37);         // lui x31,0x2
    mm[1] = enc_i(-2048, 31, 0, 31, 7'h13);  // addi x31,x31,-2048 -> 0x1800
    for (int k = 2; k < NPROG; k++) mm[k] = gen_rand();
    mm[NPROG]   = enc_j(0, 0);
    mm[NPROG+1] = enc_j(0, 0);
    for (int k = 0; k < 2048; k++) put(k, mm[k]);
    for (int k = 0; k < 32; k++) mr[k] = 32'd0;
    mpc = 32'd0;
    release_rst();
    for (int c = 0; c < NPROG + 3; c++) begin
      run(1);
      iss_step();
      check("rand_pc", dut.pc, mpc);
    end
    for (int k = 1; k < 32; k++) check("rand_reg", dut.rs[k], mr[k]);
    for (int k = 12'h400; k < 12'h800; k++) check("rand_mem", dut.memory.m[k], mm[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
